// File: rtl/clkgen_resetgen_pkg.sv
// Shared types and constants for the clock/reset generator: FSM states, tick counter width
// and the legal parameter ranges.
package clkgen_pkg;

  typedef enum logic [1:0] {
    StHold    = 2'd0,
    StStartup = 2'd1,
    StRun     = 2'd2
  } state_e;

  localparam int unsigned TICKCNT_WIDTH     = 8;
  localparam int unsigned SYNC_STAGES_MIN   = 2;
  localparam int unsigned SYNC_STAGES_MAX   = 4;
  localparam int unsigned RELEASE_DELAY_MIN = 1;
  localparam int unsigned RELEASE_DELAY_MAX = 255;

  function automatic bit in_range(int unsigned val, int unsigned lo, int unsigned hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/clkgen_resetgen_reset_synchronizer.sv
// Asynchronous-assert, synchronous-release reset synchroniser; Q rises on the SYNCSTAGES-th
// CLK posedge after RESET deasserts.
module reset_synchronizer
  import clkgen_pkg::*;
#(
  parameter int unsigned SYNCSTAGES = 2
) (
  input  logic CLK,
  input  logic RESET,
  output logic Q
);

  if (!in_range(SYNCSTAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX)) begin : gen_bad_stages
    $error("reset_synchronizer: SYNCSTAGES out of range");
  end

  logic [SYNCSTAGES-1:0] sync_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNCSTAGES-2:0], 1'b1};
    end
  end

  assign Q = sync_q[SYNCSTAGES-1];

endmodule

// File: rtl/clkgen_resetgen.sv
// Programmable glitch-free clock divider with tick strobe and a sequenced downstream reset
// that releases only after RELEASE_DELAY divided-clock periods have run.
module clkgen_resetgen
  import clkgen_pkg::*;
#(
  parameter int unsigned DIVWIDTH      = 4,
  parameter int unsigned SYNCSTAGES    = 2,
  parameter int unsigned RELEASE_DELAY = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [DIVWIDTH-1:0] DIV,
  input  logic                EN,
  output logic                CLKOUT,
  output logic                TICK,
  output logic                RESET_OUT,
  output logic                READY
);

  if (!in_range(RELEASE_DELAY, RELEASE_DELAY_MIN, RELEASE_DELAY_MAX)) begin : gen_bad_delay
    $error("clkgen_resetgen: RELEASE_DELAY out of range");
  end

  localparam logic [TICKCNT_WIDTH-1:0] TickLast = TICKCNT_WIDTH'(RELEASE_DELAY - 1);

  state_e                   state_q, state_d;
  logic [DIVWIDTH-1:0]      cnt_q, cnt_d;
  logic [DIVWIDTH-1:0]      div_q, div_d;
  logic                     clkout_q, clkout_d;
  logic                     tick_q, tick_d;
  logic [TICKCNT_WIDTH-1:0] tick_cnt_q, tick_cnt_d;
  logic                     rst_out_q, rst_out_d;
  logic                     ready_q, ready_d;
  logic                     rst_sync;
  logic                     en_eff;

  reset_synchronizer #(
    .SYNCSTAGES(SYNCSTAGES)
  ) u_sync (
    .CLK  (CLK),
    .RESET(RESET),
    .Q    (rst_sync)
  );

  // The divider must free-run during startup so the release delay always elapses.
  assign en_eff = (state_q == StRun) ? EN : 1'b1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    clkout_d   = clkout_q;
    tick_d     = 1'b0;
    tick_cnt_d = tick_cnt_q;
    rst_out_d  = rst_out_q;
    ready_d    = ready_q;
    unique case (state_q)
      StHold: begin
        cnt_d    = '0;
        clkout_d = 1'b0;
        if (rst_sync) begin
          div_d      = DIV;
          tick_cnt_d = '0;
          state_d    = StStartup;
        end
      end
      StStartup, StRun: begin
        if (cnt_q != div_q) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          // DIV is only taken at the end of a high phase so no phase is ever shortened.
          if (clkout_q) begin
            clkout_d = 1'b0;
            div_d    = DIV;
          end else if (en_eff) begin
            clkout_d = 1'b1;
            tick_d   = 1'b1;
          end
        end
        if ((state_q == StStartup) && tick_q) begin
          tick_cnt_d = tick_cnt_q + 1'b1;
          if (tick_cnt_q == TickLast) begin
            state_d   = StRun;
            rst_out_d = 1'b1;
            ready_d   = 1'b1;
          end
        end
      end
      default: state_d = StHold;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= StHold;
      cnt_q      <= '0;
      div_q      <= '0;
      clkout_q   <= 1'b0;
      tick_q     <= 1'b0;
      tick_cnt_q <= '0;
      rst_out_q  <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      clkout_q   <= clkout_d;
      tick_q     <= tick_d;
      tick_cnt_q <= tick_cnt_d;
      rst_out_q  <= rst_out_d;
      ready_q    <= ready_d;
    end
  end

  assign CLKOUT    = clkout_q;
  assign TICK      = tick_q;
  assign RESET_OUT = rst_out_q;
  assign READY     = ready_q;

endmodule

// File: tb/tb_clkgen_resetgen.sv
// Bench for clkgen_resetgen: phase-level reference model checked every cycle, plus directed
// measurements of release timing, periods, DIV changes, EN gating and async reset.
module tb_clkgen_resetgen;

  localparam int unsigned DivWidth   = 4;
  localparam int unsigned SyncStages = 2;
  localparam int unsigned RelDelay   = 4;
  localparam int unsigned RelDelayB  = 3;

  logic                clk, rst_n, en;
  logic [DivWidth-1:0] div;
  logic                clkout, tick, rst_out, ready;
  logic                clkout_b, tick_b, rst_out_b, ready_b;

  clkgen_resetgen #(
    .DIVWIDTH(DivWidth), .SYNCSTAGES(SyncStages), .RELEASE_DELAY(RelDelay)
  ) dut (
    .CLK(clk), .RESET(rst_n), .DIV(div), .EN(en),
    .CLKOUT(clkout), .TICK(tick), .RESET_OUT(rst_out), .READY(ready)
  );

  clkgen_resetgen #(
    .DIVWIDTH(DivWidth), .SYNCSTAGES(SyncStages), .RELEASE_DELAY(RelDelayB)
  ) dut_b (
    .CLK(clk), .RESET(rst_n), .DIV(div), .EN(en),
    .CLKOUT(clkout_b), .TICK(tick_b), .RESET_OUT(rst_out_b), .READY(ready_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests, n_fail, cyc;

  // Reference model: waveform as a sequence of phases, each div+1 cycles long.
  int m_stage;   // 0 hold, 1 startup, 2 run
  int m_since, m_level, m_tick, m_left, m_len, m_ticks, m_rstout, m_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_stage = 0; m_since = 0; m_level = 0; m_tick = 0; m_left = 0; m_len = 1;
    m_ticks = 0; m_rstout = 0; m_ready = 0;
  endtask

  task automatic model_edge();
    int en_eff;
    if (m_stage == 0) begin
      if (m_since == int'(SyncStages)) begin
        m_stage = 1; m_len = int'(div) + 1; m_left = m_len; m_level = 0; m_tick = 0;
        m_ticks = 0;
      end else begin
        m_since++;
      end
      return;
    end
    en_eff = (m_stage == 2) ? int'(en) : 1;
    if (m_stage == 1 && m_tick == 1) begin
      m_ticks++;
      if (m_ticks == int'(RelDelay)) begin
        m_stage = 2; m_rstout = 1; m_ready = 1;
      end
    end
    m_tick = 0;
    if (m_left > 1) begin
      m_left--;
    end else begin
      if (m_level == 1) begin
        m_level = 0;
        m_len   = int'(div) + 1;
      end else if (en_eff == 1) begin
        m_level = 1;
        m_tick  = 1;
      end
      m_left = m_len;
    end
  endtask

  task automatic compare_all();
    check("clkout", 32'(clkout), m_level);
    check("tick", 32'(tick), m_tick);
    check("reset_out", 32'(rst_out), m_rstout);
    check("ready", 32'(ready), m_ready);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    compare_all();
  endtask

  // Pulse RESET low between clock edges; outputs must drop without a clock edge.
  task automatic reset_pulse();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    check("async_ready_b", 32'(ready_b), 0);
    check("async_reset_out_b", 32'(rst_out_b), 0);
    @(negedge clk);
    #4;
    rst_n = 1'b1;
  endtask

  task automatic release_seq(input string tag);
    int d, first, rdy;
    d = int'(div); first = -1; rdy = -1;
    for (int i = 0; i < 600; i++) begin
      step();
      if (tick && first < 0) first = i;
      if (ready) begin
        rdy = i;
        break;
      end
    end
    check({tag, "_first_tick"}, first, int'(SyncStages) + d + 1);
    check({tag, "_ready_edge"}, rdy, int'(SyncStages) + d + 1 + (int'(RelDelay) - 1) * 2 * (d + 1) + 1);
  endtask

  int   rise_q[$], fall_q[$], tk_q[$];
  logic lvl_q[$];
  int   base;

  task automatic run_measure(input int n);
    logic prev;
    rise_q.delete(); fall_q.delete(); tk_q.delete(); lvl_q.delete();
    base = cyc + 1;
    prev = clkout;
    for (int i = 0; i < n; i++) begin
      step();
      lvl_q.push_back(clkout);
      if (tick) tk_q.push_back(cyc);
      if (!prev && clkout) rise_q.push_back(cyc);
      if (prev && !clkout) fall_q.push_back(cyc);
      prev = clkout;
    end
  endtask

  task automatic check_period(input string tag, input int per, input int high);
    int r1, r2, hi, nt;
    if (rise_q.size() < 2 || tk_q.size() < 2) begin
      check({tag, "_edges"}, rise_q.size(), 2);
      return;
    end
    r1 = rise_q[rise_q.size()-2];
    r2 = rise_q[rise_q.size()-1];
    hi = 0; nt = 0;
    for (int c = r1; c < r2; c++) hi += int'(lvl_q[c-base]);
    foreach (tk_q[k]) if (tk_q[k] >= r1 && tk_q[k] < r2) nt++;
    check({tag, "_period"}, r2 - r1, per);
    check({tag, "_high"}, hi, high);
    check({tag, "_ticks_per_period"}, nt, 1);
    check({tag, "_tick_spacing"}, tk_q[tk_q.size()-1] - tk_q[tk_q.size()-2], per);
    check({tag, "_tick_on_rise"}, tk_q[tk_q.size()-1], r2);
  endtask

  task automatic wait_edge(input bit want_rise, output int at);
    logic prev;
    int   found;
    found = 0;
    at = cyc;
    for (int i = 0; i < 64; i++) begin
      prev = clkout;
      step();
      if (want_rise ? (!prev && clkout) : (prev && !clkout)) begin
        at = cyc; found = 1;
        break;
      end
    end
    if (found == 0) check("wait_edge_timeout", found, 1);
  endtask

  initial begin
    int f_prev, r0, f0, cnt_b, quiet_b;
    n_tests = 0; n_fail = 0; cyc = 0;
    rst_n = 1'b0; div = 4'd1; en = 1'b1;
    model_reset();
    #1;
    compare_all();
    check("reset_ready_b", 32'(ready_b), 0);
    @(negedge clk);
    #4;
    rst_n = 1'b1;

    // Reset-release ordering with DIV = 1.
    release_seq("release");

    // Periods at DIV = 0 and DIV = 2.
    div = 4'd0;
    run_measure(12);
    run_measure(12);
    check_period("div0", 2, 1);
    div = 4'd2;
    run_measure(14);
    run_measure(20);
    check_period("div2", 6, 3);

    // DIV 3 -> 1 in the middle of a high phase.
    div = 4'd3;
    run_measure(20);
    wait_edge(1'b0, f_prev);
    wait_edge(1'b1, r0);
    step();
    div = 4'd1;
    run_measure(20);
    check("divchg_old_low", r0 - f_prev, 4);
    if (fall_q.size() >= 2 && rise_q.size() >= 1) begin
      check("divchg_cur_period", fall_q[0] - f_prev, 8);
      check("divchg_next_period", fall_q[1] - fall_q[0], 4);
      check("divchg_min_phase", rise_q[0] - fall_q[0], 2);
    end else begin
      check("divchg_edges", fall_q.size(), 2);
    end

    // EN dropped one cycle after a rise, then re-raised at a random point.
    div = 4'd3;
    run_measure(20);
    wait_edge(1'b1, r0);
    step();
    en = 1'b0;
    run_measure(30);
    f0 = (fall_q.size() > 0) ? fall_q[0] : -1;
    check("engate_high_len", f0 - r0, 4);
    check("engate_no_rise", rise_q.size(), 0);
    check("engate_no_tick", tk_q.size(), 0);
    repeat ($urandom_range(0, 7)) step();
    en = 1'b1;
    run_measure(30);
    if (rise_q.size() >= 1 && fall_q.size() >= 1) begin
      check("enrise_aligned", (rise_q[0] - f0) % 4, 0);
      check("enrise_high_len", fall_q[0] - rise_q[0], 4);
    end else begin
      check("enrise_edges", rise_q.size(), 1);
    end

    // Random DIV/EN traffic against the model.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0) div = DivWidth'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) en = ~en;
      step();
    end

    // Async reset in the middle of a high phase, then the full release sequence again.
    en = 1'b1;
    div = 4'd2;
    run_measure(40);
    wait_edge(1'b1, r0);
    check("pre_reset_clkout", 32'(clkout), 1);
    div = DivWidth'($urandom_range(0, 5));
    reset_pulse();
    release_seq("rerelease");

    // EN held low through startup: the RELEASE_DELAY=3 instance still sees 3 ticks.
    div = 4'd1;
    en = 1'b0;
    reset_pulse();
    cnt_b = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (ready_b) break;
      if (tick_b) cnt_b++;
    end
    check("en_ignored_ticks_b", cnt_b, RelDelayB);
    check("en_ignored_ready_b", 32'(ready_b), 1);
    repeat (30) step();
    quiet_b = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      quiet_b += int'(tick_b) + int'(clkout_b);
    end
    check("en_ignored_stopped_b", quiet_b, 0);
    check("en_ignored_reset_out_b", 32'(rst_out_b), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
